// File: rtl/sli_seq_pkg.sv
// Shared types and widths for the SLI pattern sequencer.
package sli_seq_pkg;

  localparam int unsigned FRQ_W           = 2;
  localparam int unsigned FRA_W           = 3;
  localparam int unsigned EXP_W           = 20;
  localparam int unsigned CNT_W           = 8;
  localparam int unsigned TRIG_CYCLES_DEF = 524288;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    SHOW,
    EXPOSE,
    WAIT_RDY,
    ADV,
    DONE
  } state_e;

  typedef struct packed {
    logic [FRQ_W-1:0] frq;
    logic [FRA_W-1:0] fra;
  } idx_t;

endpackage

// File: rtl/sync_edge.sv
// 2-FF synchroniser; EDGE=1 gives a registered rising-edge pulse, EDGE=0 the level.
module sync_edge #(
  parameter bit EDGE = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic o
);

  logic s1, s2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
    end
  end

  if (EDGE) begin : g_edge
    logic s3, re_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s3   <= 1'b0;
        re_q <= 1'b0;
      end else begin
        s3   <= s2;
        re_q <= s2 & ~s3;
      end
    end
    assign o = re_q;
  end else begin : g_level
    assign o = s2;
  end

endmodule

// File: rtl/sli_sequencer.sv
// SLI pattern controller: steps frq/fra per frame, fires the camera trigger and
// waits for camera ready, with hold frames, rdy timeout and pass-through abort.
module sli_sequencer
  import sli_seq_pkg::*;
#(
  parameter int unsigned HOLD_FRAMES    = 2,
  parameter int unsigned TRIG_CYCLES    = TRIG_CYCLES_DEF,
  parameter int unsigned TIMEOUT_FRAMES = 60,
  parameter int unsigned LAST_FRQ       = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vsync,
  input  logic             rdy,
  input  logic             mode,
  input  logic             start,
  output logic [FRQ_W-1:0] frq,
  output logic [FRA_W-1:0] fra,
  output logic             trig,
  output logic             f_frm,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_FRAMES - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_FRAMES - 1);
  localparam logic [EXP_W-1:0] EXP_LAST  = EXP_W'(TRIG_CYCLES);
  localparam logic [FRQ_W-1:0] FRQ_LAST  = FRQ_W'(LAST_FRQ);

  state_e           state, state_nxt;
  idx_t             idx, idx_nxt;
  logic [EXP_W-1:0] exp_cnt, exp_nxt;
  logic [CNT_W-1:0] hold_cnt, hold_nxt;
  logic [CNT_W-1:0] to_cnt, to_nxt;
  logic             rdy_pend, rdy_pend_nxt;
  logic             trig_nxt, done_nxt, err_nxt, busy_nxt, f_frm_nxt;
  logic             vsync_d1, vs_re, rdy_re, mode_s;

  sync_edge #(.EDGE(1'b1)) u_rdy_sync  (.clk(clk), .rst(rst), .d(rdy),  .o(rdy_re));
  sync_edge #(.EDGE(1'b0)) u_mode_sync (.clk(clk), .rst(rst), .d(mode), .o(mode_s));

  assign frq = idx.frq;
  assign fra = idx.fra;

  // State, counters and all outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      exp_cnt  <= '0;
      hold_cnt <= '0;
      to_cnt   <= '0;
      rdy_pend <= 1'b0;
      trig     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      busy     <= 1'b0;
      f_frm    <= 1'b0;
      vsync_d1 <= 1'b0;
      vs_re    <= 1'b0;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      exp_cnt  <= exp_nxt;
      hold_cnt <= hold_nxt;
      to_cnt   <= to_nxt;
      rdy_pend <= rdy_pend_nxt;
      trig     <= trig_nxt;
      done     <= done_nxt;
      err      <= err_nxt;
      busy     <= busy_nxt;
      f_frm    <= f_frm_nxt;
      vsync_d1 <= in_vsync;
      vs_re    <= in_vsync & ~vsync_d1;
    end
  end

  // Next state and next register values
  always_comb begin
    state_nxt    = state;
    idx_nxt      = idx;
    exp_nxt      = exp_cnt;
    hold_nxt     = hold_cnt;
    to_nxt       = to_cnt;
    rdy_pend_nxt = rdy_pend;
    trig_nxt     = trig;
    done_nxt     = 1'b0;
    err_nxt      = err;

    unique case (state)
      IDLE: begin
        if (start && !mode_s) begin
          state_nxt = ARM;
          err_nxt   = 1'b0;
        end
      end
      ARM: begin
        if (vs_re) begin
          state_nxt = SHOW;
          hold_nxt  = '0;
        end
      end
      SHOW: begin
        if (vs_re) begin
          if (hold_cnt == HOLD_LAST) begin
            state_nxt    = EXPOSE;
            trig_nxt     = 1'b1;
            exp_nxt      = EXP_W'(1);
            rdy_pend_nxt = 1'b0;
          end else begin
            hold_nxt = hold_cnt + CNT_W'(1);
          end
        end
      end
      EXPOSE: begin
        exp_nxt = exp_cnt + EXP_W'(1);
        if (rdy_re) rdy_pend_nxt = 1'b1;
        if (exp_cnt == EXP_LAST) begin
          trig_nxt  = 1'b0;
          state_nxt = WAIT_RDY;
          to_nxt    = '0;
        end
      end
      WAIT_RDY: begin
        // a ready edge outranks a same-cycle vsync edge
        if (rdy_re || rdy_pend) begin
          rdy_pend_nxt = 1'b0;
          state_nxt    = (idx.frq == FRQ_LAST && idx.fra == '1) ? DONE : ADV;
        end else if (vs_re) begin
          if (to_cnt == TO_LAST) begin
            err_nxt   = 1'b1;
            state_nxt = IDLE;
            idx_nxt   = '0;
          end else begin
            to_nxt = to_cnt + CNT_W'(1);
          end
        end
      end
      ADV: begin
        // indices move only right after a vsync edge so no frame mixes patterns
        if (vs_re) begin
          if (idx.fra == '1) begin
            idx_nxt.fra = '0;
            idx_nxt.frq = idx.frq + FRQ_W'(1);
          end else begin
            idx_nxt.fra = idx.fra + FRA_W'(1);
          end
          hold_nxt  = '0;
          state_nxt = SHOW;
        end
      end
      DONE: begin
        done_nxt  = 1'b1;
        idx_nxt   = '0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    if (mode_s && state != IDLE) begin
      state_nxt    = IDLE;
      trig_nxt     = 1'b0;
      idx_nxt      = '0;
      done_nxt     = 1'b0;
      err_nxt      = err;
      rdy_pend_nxt = 1'b0;
    end

    busy_nxt  = (state_nxt != IDLE);
    f_frm_nxt = busy_nxt && (idx_nxt == '0);
  end

endmodule

// File: tb/tb_sli_sequencer.sv
// Directed bench for sli_sequencer: scoreboard of expected pattern indices per trigger.
module tb_sli_sequencer;

  localparam int unsigned TRIG_N = 16;

  logic       clk, rst, in_vsync, rdy, mode, start;
  logic [1:0] frq;
  logic [2:0] fra;
  logic       trig, f_frm, busy, done, err;

  int tests = 0;
  int fails = 0;

  logic [4:0] sb[$];
  bit  mon_en = 1'b0;
  bit  first_pat = 1'b1;
  int  done_cnt = 0, trig_cnt = 0, bad_ffrm = 0, vs_total = 0;
  bit  ffrm_seen = 1'b0;

  sli_sequencer #(
    .HOLD_FRAMES(2), .TRIG_CYCLES(TRIG_N), .TIMEOUT_FRAMES(4), .LAST_FRQ(3)
  ) dut (
    .clk(clk), .rst(rst), .in_vsync(in_vsync), .rdy(rdy), .mode(mode), .start(start),
    .frq(frq), .fra(fra), .trig(trig), .f_frm(f_frm), .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 200-cycle frame, vsync high for 10 cycles
  initial begin
    in_vsync = 1'b0;
    forever begin
      repeat (190) @(negedge clk);
      in_vsync = 1'b1;
      repeat (10) @(negedge clk);
      in_vsync = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_trig(input logic lvl, input string tag);
    int n = 0;
    while (trig !== lvl && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(trig), 32'(lvl));
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic rdy_pulse();
    rdy = 1'b1;
    repeat (3) @(negedge clk);
    rdy = 1'b0;
  endtask

  // Monitor: trigger width, pattern order, vsync alignment, f_frm and done
  logic       vs_prev = 1'b0, trig_prev = 1'b0;
  logic [4:0] idx_prev = '0;
  int         since_vs = 0, vs_since_chg = 0, width = 0;
  always @(posedge clk) begin
    logic [4:0] idx, e;
    #2;
    idx = {frq, fra};
    if (in_vsync && !vs_prev) begin
      since_vs = 0;
      vs_total++;
      vs_since_chg++;
    end else begin
      since_vs++;
    end
    vs_prev = in_vsync;
    if (idx != idx_prev && idx != 5'd0) begin
      if (mon_en) chk("idx_chg_after_vs", since_vs, 1);
      vs_since_chg = 0;
    end
    idx_prev = idx;
    if (trig && !trig_prev) begin
      width = 0;
      if (mon_en) begin
        trig_cnt++;
        if (sb.size() == 0) chk("sb_underflow", 1, 0);
        else begin
          e = sb.pop_front();
          chk("trig_idx", 32'(idx), 32'(e));
        end
        chk("trig_after_vs", since_vs, 1);
        if (!first_pat) chk("hold_vs", vs_since_chg, 2);
        first_pat = 1'b0;
      end
    end
    if (trig) width++;
    if (!trig && trig_prev && mon_en) chk("trig_width", width, TRIG_N);
    trig_prev = trig;
    if (mon_en) begin
      if (f_frm !== (busy && idx == 5'd0)) bad_ffrm++;
      if (f_frm && trig && idx == 5'd0) ffrm_seen = 1'b1;
    end
    if (done) done_cnt++;
  end

  initial begin
    int n, vs_mark;
    rst = 1'b1; rdy = 1'b0; mode = 1'b0; start = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_frq", 32'(frq), 0);
    chk("rst_fra", 32'(fra), 0);
    chk("rst_trig", 32'(trig), 0);
    chk("rst_f_frm", 32'(f_frm), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    rst = 1'b0;

    // asynchronous reset in the middle of an exposure
    pulse_start();
    wait_trig(1'b1, "r_trig_rise");
    repeat (4) @(negedge clk);
    chk("r_trig_high", 32'(trig), 1);
    #1 rst = 1'b1;
    #1;
    chk("r_async_trig", 32'(trig), 0);
    chk("r_async_busy", 32'(busy), 0);
    chk("r_async_frq", 32'(frq), 0);
    chk("r_async_fra", 32'(fra), 0);
    @(negedge clk) rst = 1'b0;
    repeat (3) @(negedge clk);

    // full sequence; every 5th pattern gets its rdy during the trigger window
    for (int p = 0; p < 32; p++) sb.push_back(5'(p));
    first_pat = 1'b1; done_cnt = 0; trig_cnt = 0; bad_ffrm = 0; ffrm_seen = 1'b0;
    mon_en = 1'b1;
    pulse_start();
    for (int p = 0; p < 32; p++) begin
      wait_trig(1'b1, "run_rise");
      if (p % 5 == 2) begin
        repeat (3) @(negedge clk);
        rdy_pulse();
        wait_trig(1'b0, "run_fall_pend");
      end else begin
        wait_trig(1'b0, "run_fall");
        repeat (10) @(negedge clk);
        rdy_pulse();
      end
    end
    n = 0;
    while (busy !== 1'b0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    mon_en = 1'b0;
    chk("run_busy_end", 32'(busy), 0);
    chk("run_done_cnt", done_cnt, 1);
    chk("run_trig_cnt", trig_cnt, 32);
    chk("run_sb_left", sb.size(), 0);
    chk("run_f_frm_bad", bad_ffrm, 0);
    chk("run_f_frm_seen", 32'(ffrm_seen), 1);
    chk("run_err", 32'(err), 0);
    chk("run_idx_end", 32'({frq, fra}), 0);

    // rdy never arrives after pattern 0:3
    done_cnt = 0;
    pulse_start();
    for (int p = 0; p < 4; p++) begin
      wait_trig(1'b1, "to_rise");
      wait_trig(1'b0, "to_fall");
      if (p < 3) begin
        repeat (10) @(negedge clk);
        rdy_pulse();
      end
    end
    chk("to_idx", 32'({frq, fra}), 32'(5'd3));
    vs_mark = vs_total;
    n = 0;
    while (err !== 1'b1 && n < 1200) begin
      @(negedge clk);
      n++;
    end
    chk("to_err", 32'(err), 1);
    chk("to_vs_count", vs_total - vs_mark, 4);
    chk("to_busy", 32'(busy), 0);
    chk("to_idx_clr", 32'({frq, fra}), 0);
    pulse_start();
    chk("to_err_clr", 32'(err), 0);
    chk("to_restart_busy", 32'(busy), 1);

    // pass-through abort at pattern 2:5 while the trigger is high
    for (int p = 0; p < 21; p++) begin
      wait_trig(1'b1, "ab_rise");
      wait_trig(1'b0, "ab_fall");
      repeat (10) @(negedge clk);
      rdy_pulse();
    end
    wait_trig(1'b1, "ab_rise_2_5");
    chk("ab_idx", 32'({frq, fra}), 32'(5'd21));
    repeat (2) @(negedge clk);
    mode = 1'b1;
    n = 0;
    while (trig !== 1'b0 && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk("ab_trig_low", 32'(trig), 0);
    chk("ab_latency_le4", 32'(n <= 4), 1);
    chk("ab_busy", 32'(busy), 0);
    chk("ab_idx_clr", 32'({frq, fra}), 0);
    chk("ab_err", 32'(err), 0);
    pulse_start();
    repeat (5) @(negedge clk);
    chk("ab_start_ignored", 32'(busy), 0);
    chk("ab_trig_idle", 32'(trig), 0);
    mode = 1'b0;
    repeat (5) @(negedge clk);
    chk("ab_no_done", done_cnt, 0);
    chk("ab_still_idle", 32'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sli_sequencer.md
Name: sli_sequencer

Overview:
- Owns the SLI pattern sequence for the pixel pipe: produces the spatial-frequency index (frq) and frame index (fra) that the pixel pipe uses for LUT indexing and BW flash frames.
- Generates the camera trigger pulse and waits for the camera ready handshake before advancing.
- Replaces free-running per-vsync counting with an explicit controller: hold frames, exposure window, rdy timeout, and abort on pass-through mode.
- Sits on the pixel clock, between the HDMI timing inputs and the pixel pipe's index mapping and trigger output.

Parameters:
- HOLD_FRAMES, 2: vsync rising edges a new pattern must be displayed before exposure starts (≥1).
- TRIG_CYCLES, 524288: trig high time in clk cycles (0x80000, ≈7.06 ms at pixel clock).
- TIMEOUT_FRAMES, 60: vsync rising edges allowed in WAIT_RDY before error (≥1).
- LAST_FRQ, 3: final frq value; sequence covers frq 0..LAST_FRQ × fra 0..7.

Ports:
- clk  in  1  pixel clock
- rst  in  1  reset; asynchronous, active-high
- in_vsync  in  1  vsync, synchronous to clk
- rdy  in  1  camera ready, asynchronous, 2-FF synchronised internally
- mode  in  1  1 = pass-through, asynchronous switch, 2-FF synchronised
- start  in  1  single-cycle request to run one full sequence
- frq  out  2  spatial frequency index
- fra  out  3  frame index within frq
- trig  out  1  camera exposure trigger
- f_frm  out  1  high while busy and frq==0 and fra==0
- busy  out  1  sequence in progress (state ≠ IDLE)
- done  out  1  one-cycle pulse on sequence completion
- err  out  1  sticky rdy-timeout flag; cleared by rst or accepted start

Behaviour:
- Reset: state IDLE; frq=0, fra=0, trig=0, f_frm=0, busy=0, done=0, err=0; all counters and the rdy_pend flag cleared.
- vs_re = in_vsync & ~in_vsync_d1 (registered). rdy_re / mode_s come from the synchroniser outputs, so there are 2–3 cycles of latency from the pins.
- States:
  - IDLE: start & ~mode_s → ARM, err←0. start while busy or while mode_s=1 is ignored.
  - ARM: on vs_re → SHOW, hold_cnt←0. Indices are already 0.
  - SHOW: each vs_re increments hold_cnt. On the vs_re where hold_cnt==HOLD_FRAMES-1 → EXPOSE, trig←1, exp_cnt←1, rdy_pend←0.
  - EXPOSE: exp_cnt increments each cycle. When exp_cnt==TRIG_CYCLES, trig←0 → WAIT_RDY, to_cnt←0. trig is therefore high for exactly TRIG_CYCLES cycles. A rdy_re seen during EXPOSE sets rdy_pend.
  - WAIT_RDY: rdy_re or rdy_pend → ADV if (frq,fra) ≠ (LAST_FRQ,7), else DONE. Each vs_re increments to_cnt; to_cnt reaching TIMEOUT_FRAMES → err←1, IDLE, indices←0.
  - ADV: on vs_re, fra←fra+1; when fra==7, fra←0 and frq←frq+1; hold_cnt←0; → SHOW. Indices change only in the cycle after a vs_re, so every displayed frame uses a single pattern.
  - DONE: done=1 for one cycle, indices←0 → IDLE.
- Abort: mode_s=1 in any non-IDLE state → IDLE next cycle, trig←0 immediately (registered), indices←0, no done, err unchanged. Abort has priority over every other transition, including a simultaneous vs_re or rdy_re.
- vs_re and rdy_re in the same cycle in WAIT_RDY: rdy wins, no timeout increment.
- The frq=3 BW flash frames are ordinary patterns here; the pixel pipe alone decides the content.
- Counters: exp_cnt 20 bits, hold_cnt and to_cnt 8 bits, all saturate-free because they are bounded by the parameters.
- All outputs are registered; there is no combinational path from inputs to outputs.

Decomposition:
- Package sli_seq_pkg holds:
  - state encoding: IDLE, ARM, SHOW, EXPOSE, WAIT_RDY, ADV, DONE (3-bit)
  - FRQ_W=2, FRA_W=3, EXP_W=20
  - default TRIG_CYCLES constant
- Sub-module sync_edge: 2-FF synchroniser plus registered rising-edge detect, async active-high rst. Instanced for rdy (edge used) and mode (level used).

Test Plan (bench params: HOLD_FRAMES=2, TRIG_CYCLES=16, TIMEOUT_FRAMES=4, vsync period 200 cycles):
- Reset mid-EXPOSE (assert rst at trig-high cycle 5) → trig, busy, frq, fra = 0 in the same cycle, without waiting for a clock edge.
- start, then a rdy pulse 10 cycles after each trig falls → trig high for exactly 16 cycles per pattern; 32 trig pulses; frq:fra steps 0:0..3:7; done pulses once; f_frm high only during pattern 0:0.
- Indices change only in the cycle after a vsync edge; exposure starts on the 2nd vs_re after each index change.
- rdy pulse during the trig-high window → rdy_pend is consumed; ADV is entered on the first cycle of WAIT_RDY.
- No rdy after pattern 0:3 → after 4 vs_re, err=1, busy=0, frq=fra=0; a new start clears err.
- mode raised at pattern 2:5 while trig is high → trig=0 ≤4 cycles after the pin changes, state IDLE, done never asserted; start with mode=1 is ignored.
